// File: rtl/lvds_defs.sv
// Shared LVDS IQ definitions: sync bits, word geometry, FIFO fields, states.
package lvds_defs;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  localparam int WORD_BITS      = 32;
  localparam int PAIRS_PER_WORD = WORD_BITS / 2;

  localparam int FIFO_W = 32;
  localparam int I_LSB  = 16;
  localparam int Q_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/lvds_tx_framer.sv
// Builds the framed modem IQ word {I_SYNC, I, 0, Q_SYNC, Q, 0}.
// With LVDS_TX_TEST_PATTERN_EN a ramp (I=r, Q=~r) can replace FIFO data.
module lvds_tx_framer
  import lvds_defs::*;
#(
  parameter int SAMPLE_BITS = 13
) (
  input  logic [FIFO_W-1:0]        fifo_data_i,
`ifdef LVDS_TX_TEST_PATTERN_EN
  input  logic                     test_mode_i,
  input  logic [SAMPLE_BITS-1:0]   ramp_i,
`endif
  output logic [2*SAMPLE_BITS+5:0] word_o
);

  logic [SAMPLE_BITS-1:0] i_smp;
  logic [SAMPLE_BITS-1:0] q_smp;

  // Bits outside the I and Q fields carry no payload.
  logic unused_bits;
  assign unused_bits = ^{
    fifo_data_i[FIFO_W-1:I_LSB+SAMPLE_BITS],
    fifo_data_i[I_LSB-1:Q_LSB+SAMPLE_BITS]
  };

  always_comb begin
    i_smp = fifo_data_i[I_LSB +: SAMPLE_BITS];
    q_smp = fifo_data_i[Q_LSB +: SAMPLE_BITS];
`ifdef LVDS_TX_TEST_PATTERN_EN
    if (test_mode_i) begin
      i_smp = ramp_i;
      q_smp = ~ramp_i;
    end
`endif
  end

  assign word_o = {
    I_SYNC, i_smp, 1'b0,
    Q_SYNC, q_smp, 1'b0
  };

endmodule

// File: rtl/lvds_tx.sv
// LVDS IQ transmitter: pulls I/Q pairs, frames and shifts 2 bits/cycle.
// Optional ramp test source: define LVDS_TX_TEST_PATTERN_EN.
module lvds_tx
  import lvds_defs::*;
#(
  parameter int SAMPLE_BITS    = 13,
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                      i_ddr_clk,
  input  logic                      i_reset,
  input  logic                      i_tx_enable,
  input  logic                      i_fifo_empty,
  output logic                      o_fifo_pull,
  input  logic [FIFO_W-1:0]         i_fifo_data,
  output logic [1:0]                o_ddr_data,
  output logic                      o_tx_active,
  output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt,
  input  logic                      i_test_mode
);

  localparam int WB    = 2 * SAMPLE_BITS + 6;
  localparam int PAIRS = WB / 2;
  localparam int CW    = $clog2(PAIRS);

  // Inputs sampled at the edge entering pair PAIRS-2 (pull visible there).
  localparam logic [CW-1:0] CNT_PF   = CW'(PAIRS - 3);
  localparam logic [CW-1:0] CNT_LAST = CW'(PAIRS - 1);

  tx_state_e                 state_q;
  logic [CW-1:0]             cnt_q;
  logic [WB-1:0]             shift_q;
  logic [1:0]                ddr_q;
  logic                      pull_q;
  logic                      act_q;
  logic                      pf_q;
  logic [UNDERRUN_CNT_W-1:0] und_q;

  logic [WB-1:0] word;
  logic          tm;
  logic          pull_ok;
  logic          tm_go;
  logic          load;

`ifdef LVDS_TX_TEST_PATTERN_EN
  logic [SAMPLE_BITS-1:0] ramp_q;

  assign tm = i_test_mode;

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      ramp_q <= '0;
    end else if (load && tm) begin
      ramp_q <= ramp_q + SAMPLE_BITS'(1);
    end
  end

  lvds_tx_framer #(
    .SAMPLE_BITS (SAMPLE_BITS)
  ) u_framer (
    .fifo_data_i (i_fifo_data),
    .test_mode_i (tm),
    .ramp_i      (ramp_q),
    .word_o      (word)
  );
`else
  logic unused_tm;
  assign unused_tm = i_test_mode;
  assign tm        = 1'b0;

  lvds_tx_framer #(
    .SAMPLE_BITS (SAMPLE_BITS)
  ) u_framer (
    .fifo_data_i (i_fifo_data),
    .word_o      (word)
  );
`endif

  assign pull_ok = i_tx_enable && !i_fifo_empty && !tm;
  assign tm_go   = i_tx_enable && tm;

  assign load = (state_q == PRIME) ||
                ((state_q == SHIFT) &&
                 (cnt_q == CNT_LAST) && pf_q);

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ddr_q   <= 2'b00;
      pull_q  <= 1'b0;
      act_q   <= 1'b0;
      pf_q    <= 1'b0;
      und_q   <= '0;
    end else begin
      pull_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ddr_q <= 2'b00;
          act_q <= 1'b0;
          cnt_q <= '0;
          if (pull_q) begin
            state_q <= PRIME;
          end else if (pull_ok) begin
            pull_q <= 1'b1;
          end else if (tm_go) begin
            state_q <= PRIME;
          end
        end
        PRIME: begin
          shift_q <= word;
          ddr_q   <= word[WB-1:WB-2];
          act_q   <= 1'b1;
          cnt_q   <= '0;
          pf_q    <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_PF) begin
            if (pull_ok) begin
              pull_q <= 1'b1;
              pf_q   <= 1'b1;
            end else if (tm_go) begin
              pf_q <= 1'b1;
            end else if (i_tx_enable && !tm &&
                         (und_q != '1)) begin
              und_q <= und_q + UNDERRUN_CNT_W'(1);
            end
          end
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            pf_q  <= 1'b0;
            if (pf_q) begin
              shift_q <= word;
              ddr_q   <= word[WB-1:WB-2];
            end else begin
              ddr_q   <= 2'b00;
              act_q   <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            shift_q <= {shift_q[WB-3:0], 2'b00};
            ddr_q   <= shift_q[WB-3:WB-4];
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_fifo_pull    = pull_q;
  assign o_ddr_data     = ddr_q;
  assign o_tx_active    = act_q;
  assign o_underrun_cnt = und_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: FIFO model, pair monitor, word-level reference.
module tb_lvds_tx;

  localparam int UW  = 4;
  localparam int SAT = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_tx_enable;
  logic          i_fifo_empty;
  logic          o_fifo_pull;
  logic [31:0]   i_fifo_data = '0;
  logic [1:0]    o_ddr_data;
  logic          o_tx_active;
  logic [UW-1:0] o_underrun_cnt;
  logic          i_test_mode;

  always #5 clk = ~clk;

  lvds_tx #(
    .SAMPLE_BITS    (13),
    .UNDERRUN_CNT_W (UW)
  ) dut (
    .i_ddr_clk      (clk),
    .i_reset        (i_reset),
    .i_tx_enable    (i_tx_enable),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_pull    (o_fifo_pull),
    .i_fifo_data    (i_fifo_data),
    .o_ddr_data     (o_ddr_data),
    .o_tx_active    (o_tx_active),
    .o_underrun_cnt (o_underrun_cnt),
    .i_test_mode    (i_test_mode)
  );

  // FIFO model: written by the stimulus, read on pull.
  logic [31:0] mem [256];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr = '0;
  int          pull_empty_n = 0;

  assign i_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (o_fifo_pull) begin
      if (wr_ptr == rd_ptr) begin
        pull_empty_n++;
      end else begin
        i_fifo_data <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 8'd1;
      end
    end
  end

  // Monitor: reassembles 16 active pairs into words.
  int          cyc = 0;
  int          pn = 0;
  int          rx_n = 0;
  int          pc = 0;
  int          partial_n = 0;
  int          idle_bad_n = 0;
  int          pull_cyc [256];
  int          rx_start [256];
  logic [31:0] rx_word [256];
  logic [31:0] acc = '0;

  always @(negedge clk) begin
    cyc++;
    if (o_fifo_pull && pn < 256) begin
      pull_cyc[pn] = cyc;
      pn++;
    end
    if (o_tx_active) begin
      if (pc == 0 && rx_n < 256) rx_start[rx_n] = cyc;
      acc = {acc[29:0], o_ddr_data};
      pc++;
      if (pc == 16) begin
        if (rx_n < 256) rx_word[rx_n] = acc;
        rx_n++;
        pc = 0;
      end
    end else begin
      if (pc != 0) partial_n++;
      pc = 0;
      if (o_ddr_data != 2'b00) idle_bad_n++;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_w [256];
  int          exp_n = 0;
  int          exp_chk = 0;
  int          rx_chk = 0;
  int          und_model = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frame(
    input logic [12:0] i, input logic [12:0] q);
    return {2'b10, i, 1'b0, 2'b01, q, 1'b0};
  endfunction

  task automatic push(input logic [12:0] i,
                      input logic [12:0] q);
    logic [2:0] j1, j2;
    j1 = 3'($urandom);
    j2 = 3'($urandom);
    mem[wr_ptr] = {j1, i, j2, q};
    wr_ptr      = wr_ptr + 8'd1;
    exp_w[exp_n] = frame(i, q);
    exp_n++;
  endtask

  task automatic push_rand();
    push(13'($urandom), 13'($urandom));
  endtask

  task automatic settle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (!o_tx_active && !o_fifo_pull) quiet++;
      else quiet = 0;
    end
    check("settle", quiet, 4);
  endtask

  task automatic wait_active(input int budget);
    int n = 0;
    while (!o_tx_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start", {31'd0, o_tx_active}, 1);
  endtask

  task automatic check_words();
    while (rx_chk < rx_n && exp_chk < exp_n) begin
      check("word", rx_word[rx_chk], exp_w[exp_chk]);
      rx_chk++;
      exp_chk++;
    end
  endtask

  task automatic check_und();
    int e;
    e = (und_model > SAT) ? SAT : und_model;
    check("underrun", {28'd0, o_underrun_cnt}, e);
  endtask

  // Words already queued; transmit them as one burst.
  task automatic run(input int n);
    int rx0, pn0;
    rx0 = rx_n;
    pn0 = pn;
    i_tx_enable = 1'b1;
    settle(20 * n + 60);
    check("nwords", rx_n - rx0, n);
    check("npulls", pn - pn0, n);
    if (rx_n > rx0 && pn > pn0)
      check("latency", rx_start[rx0] - pull_cyc[pn0], 2);
    for (int k = 1; k < n; k++)
      if (rx0 + k < rx_n)
        check("gap", rx_start[rx0+k] - rx_start[rx0+k-1], 16);
    und_model++;
    check_words();
    check_und();
  endtask

  initial begin
    i_reset     = 1'b1;
    i_tx_enable = 1'b0;
    i_test_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ddr", {30'd0, o_ddr_data}, 0);
    check("rst_pull", {31'd0, o_fifo_pull}, 0);
    check("rst_act", {31'd0, o_tx_active}, 0);
    check("rst_und", {28'd0, o_underrun_cnt}, 0);
    i_reset = 1'b0;
    @(negedge clk);

    // Single known word.
    push(13'h0155, 13'h1AAA);
    check("frame", exp_w[0], 32'h82AA7554);
    run(1);

    // Three back-to-back words.
    i_tx_enable = 1'b0;
    for (int k = 0; k < 3; k++) push_rand();
    run(3);

    // Enable dropped mid-word with data still queued.
    begin
      int rx0, pn0;
      i_tx_enable = 1'b0;
      for (int k = 0; k < 3; k++) push_rand();
      rx0 = rx_n;
      pn0 = pn;
      i_tx_enable = 1'b1;
      wait_active(20);
      repeat (5) @(negedge clk);
      i_tx_enable = 1'b0;
      settle(60);
      check("drop_words", rx_n - rx0, 1);
      check("drop_pulls", pn - pn0, 1);
      check_words();
      check_und();
      run(2);
    end

    // Random bursts, then drive the counter into saturation.
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 4);
      i_tx_enable = 1'b0;
      for (int k = 0; k < n; k++) push_rand();
      run(n);
    end
    while (und_model < SAT + 2) begin
      i_tx_enable = 1'b0;
      push_rand();
      run(1);
    end

    // Reset at pair 7 of a word.
    begin
      int pn0;
      i_tx_enable = 1'b0;
      push_rand();
      push_rand();
      i_tx_enable = 1'b1;
      wait_active(20);
      repeat (7) @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      check("abort_ddr", {30'd0, o_ddr_data}, 0);
      check("abort_act", {31'd0, o_tx_active}, 0);
      check("abort_und", {28'd0, o_underrun_cnt}, 0);
      i_reset = 1'b0;
      und_model = 0;
      exp_chk++;
      pn0 = pn;
      settle(80);
      check("retx_pulls", pn - pn0, 1);
      und_model++;
      check_words();
      check_und();
    end

`ifdef LVDS_TX_TEST_PATTERN_EN
    begin
      int pn0;
      i_tx_enable = 1'b0;
      i_test_mode = 1'b1;
      for (int k = 0; k < 3; k++)
        exp_w[exp_n + k] = frame(13'(k), ~13'(k));
      pn0 = pn;
      i_tx_enable = 1'b1;
      wait_active(20);
      repeat (40) @(negedge clk);
      i_tx_enable = 1'b0;
      settle(80);
      check("tm_pulls", pn - pn0, 0);
      for (int k = 0; k < 3; k++)
        check("tm_word", rx_word[rx_chk + k], exp_w[exp_n + k]);
      check_und();
      i_test_mode = 1'b0;
    end
`endif

    check("pull_empty", pull_empty_n, 0);
    check("idle_ddr", idle_bad_n, 0);
    check("partial", partial_n, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_tx.md
Name: lvds_tx

Overview:
- Transmit-side counterpart of the modem LVDS IQ receiver.
- Pulls 13-bit I/Q sample pairs from the TX complex FIFO (read side) and frames each pair into a 32-bit modem IQ word with I/Q sync bits.
- Serialises each word MSB-first, 2 bits per LVDS clock cycle, to DDR output SB_IO cells driving o_iq_tx_p/n.
- Runs entirely in the LVDS TX clock domain; FIFO write side and control live in the sys clock domain.

Parameters:
- SAMPLE_BITS, 13, width of each I and Q sample field.
- UNDERRUN_CNT_W, 16, width of the saturating underrun counter.

Ports:
- i_ddr_clk  input  1  LVDS TX clock; the only clock.
- i_reset  input  1  synchronous, active-high reset.
- i_tx_enable  input  1  level; high = transmit when data is available.
- i_fifo_empty  input  1  TX FIFO empty flag.
- o_fifo_pull  output  1  one-cycle FIFO read strobe.
- i_fifo_data  input  32  FIFO read data, valid 1 cycle after pull; I = [28:16], Q = [12:0], other bits ignored.
- o_ddr_data  output  2  [1] = earlier bit (rising half), [0] = later bit (falling half); feeds SB_IO D_OUT_0/D_OUT_1.
- o_tx_active  output  1  high while a word is being shifted.
- o_underrun_cnt  output  UNDERRUN_CNT_W  saturating count of underruns.
- i_test_mode  input  1  test-pattern select; used only with the optional feature.

Behaviour:
- Clock and reset: one clock (i_ddr_clk); reset (i_reset) is synchronous and active-high.
- Reset values: o_ddr_data=2'b00, o_fifo_pull=0, o_tx_active=0, o_underrun_cnt=0, state=IDLE, frame counter=0.
- Reset mid-word aborts the word immediately; the next cycle outputs 00.
- Word format, MSB first: {2'b10, I[12:0], 1'b0, 2'b01, Q[12:0], 1'b0}.
- In frame cycle k (0..15), o_ddr_data = word[31-2k:30-2k].
- All outputs are registered.

FSM:
- IDLE:
  - o_ddr_data=00.
  - If i_tx_enable & !i_fifo_empty: assert o_fifo_pull for 1 cycle, go to PRIME.
- PRIME:
  - i_fifo_data is valid this cycle; load the framed word into the shift register; go to SHIFT with count=0.
  - Latency: the first pair (2'b10) appears on o_ddr_data in the cycle after PRIME, i.e. 2 cycles after the pull.
- SHIFT:
  - o_tx_active=1; count increments each cycle.
  - At count=14: if i_tx_enable & !i_fifo_empty, pull (prefetch).
  - At count=15, prefetched case: the new word loads at the end of the cycle and count wraps to 0. Words are back-to-back with no gap.
  - At count=15, no prefetch: go to IDLE.
  - Underrun: i_tx_enable=1 and empty at count=14. o_underrun_cnt increments by 1, saturating at all-ones.
  - i_tx_enable low at count=14 is not an underrun.
- Partial words are never sent. Deasserting i_tx_enable mid-word finishes that word, then goes to IDLE.
- i_fifo_empty is sampled only in IDLE and at count=14. o_fifo_pull is never asserted while empty.
- Exactly one pull is issued per transmitted word.

Optional Feature:
- Macro: LVDS_TX_TEST_PATTERN_EN.
- Defined, and i_test_mode=1:
  - FIFO is ignored and o_fifo_pull stays 0.
  - An internal 13-bit ramp r (reset 0, +1 per word, wraps at 0x1FFF→0) supplies I=r, Q=~r.
  - Words are continuous while i_tx_enable=1; no underruns are counted.
- Undefined: i_test_mode is ignored; no ramp logic is synthesised.

Decomposition:
- Shared package/include (lvds_defs) with:
  - sync constants I_SYNC=2'b10, Q_SYNC=2'b01;
  - WORD_BITS=32, PAIRS_PER_WORD=16;
  - field positions for I/Q in FIFO data;
  - state encodings IDLE/PRIME/SHIFT.
- The receiver uses the same package.
- One natural sub-module: lvds_tx_framer (combinational I/Q → 32-bit word, with ramp source under the macro).

Test Plan:
- FIFO holds one word, I=0x0155, Q=0x1AAA, enable=1 -> one pull. o_ddr_data shows word 0x82AA7554 MSB-first over 16 cycles, starting 2 cycles after the pull, then returns to 00. o_underrun_cnt=1.
- Three words queued, enable=1 -> pulls at PRIME-1 and at count 14 of each word. 48 consecutive active cycles with no gap; each word starts with pair 10 and has 01 at pair 8. o_underrun_cnt=1 after the last word.
- Enable dropped at count 5 of word 1 (FIFO non-empty) -> word 1 completes all 16 pairs; no further pull; o_underrun_cnt unchanged.
- Reset asserted at count 7 -> next cycle o_ddr_data=00, o_tx_active=0, counter=0. Retransmission starts from a new pull with pair 10.
- o_underrun_cnt pre-driven to 0xFFFE via repeated single-word bursts -> saturates at 0xFFFF, never wraps.
- With LVDS_TX_TEST_PATTERN_EN and i_test_mode=1 -> first words carry I=0,1,2 and Q=0x1FFF,0x1FFE,0x1FFD. o_fifo_pull stays 0.
